xdma_to_remote_arbiter: RTL and testbench
=========================================

XDMA_TO_REMOTE_ARBITER -- requirements
Module: xdma_to_remote_arbiter

Interface
REQ-001 Parameters SHALL be: NumInp, default 4 (xdma_pkg NUM_INP), number of to-remote message sources; DataWidth, default 512 (AxiDataWidth), beat width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk_i and rst_i.
REQ-003 Ports SHALL be, clock and reset first:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- inp_data_i  in  NumInp x DataWidth  message beats, indexed by xdma_to_remote_idx_e (0 Finish, 1 Grant, 2 Cfg, 3 Data)
- inp_last_i  in  NumInp  last beat of a message (single-beat messages hold it at 1)
- inp_valid_i  in  NumInp  beat valid per source
- inp_ready_o  out  NumInp  beat accepted per source
- oup_data_o  out  DataWidth  arbitrated beat
- oup_idx_o  out  2  source index (xdma_req_idx_t)
- oup_last_o  out  1  last beat of the message
- oup_valid_o  out  1  output beat valid
- oup_ready_i  in  1  downstream ready
- busy_o  out  1  lock held or output register full

Function
REQ-004 Input and output handshakes SHALL be valid/ready; a beat transfers on a cycle with valid and ready both high; each source SHALL hold valid and data stable until accepted.
REQ-005 Arbitration SHALL be message-granular: a source that wins keeps the grant until its beat with inp_last_i=1 is accepted.
REQ-006 The FSM SHALL have two states. IDLE: no lock. LOCKED(idx): only source idx may be granted.
REQ-007 In IDLE, accepting a beat with last=0 SHALL enter LOCKED(winner); accepting a beat with last=1 SHALL stay in IDLE.
REQ-008 In LOCKED, accepting a beat with last=1 SHALL return to IDLE; other sources' valids SHALL be ignored.
REQ-009 In IDLE, the winner SHALL be chosen by the policy in REQ-019/REQ-020 among sources with valid=1.
REQ-010 inp_ready_o[i] SHALL be 1 only for the granted i, and only when the output register is empty or oup_ready_i=1; all other bits SHALL be 0.
REQ-011 The output SHALL be one register stage: latency is one cycle from input acceptance to oup_valid_o=1, and sustained throughput is one beat per cycle when oup_ready_i=1.
REQ-012 When oup_valid_o=1 and oup_ready_i=0, oup_data_o, oup_idx_o and oup_last_o SHALL stay stable, and no input SHALL be accepted.
REQ-013 A simultaneous output pop and input accept SHALL reload the register in the same cycle, with no bubble.
REQ-014 busy_o SHALL equal (state==LOCKED) OR oup_valid_o.
REQ-015 The grant decision SHALL be combinational from current state and valids; no combinational path SHALL exist from inp_valid_i to oup_valid_o.

Reset
REQ-016 With rst_i high at a clock edge: state=IDLE, oup_valid_o=0, oup_data_o=0, oup_idx_o=0, oup_last_o=0, busy_o=0, round-robin pointer=0.
REQ-017 While rst_i is high, inp_ready_o SHALL be all 0.
REQ-018 Reset mid-message SHALL drop the lock and any registered beat without emitting it; the next message starts fresh in IDLE.

Configuration
REQ-019 Macro XDMA_TO_REMOTE_ARB_RR_EN SHALL be defined: IDLE arbitration SHALL be round-robin; the search starts at the pointer and wraps at NumInp-1 to 0; on a message's last-beat acceptance the pointer becomes (winner+1) mod NumInp.
REQ-020 Macro not defined: IDLE arbitration SHALL be fixed priority with the lowest index winning (Finish > Grant > Cfg > Data); no pointer register SHALL exist; starvation of lower-priority sources is permitted.

Verification
REQ-021 Reset, then Grant valid, 1 beat, last=1, data=0xA5, oup_ready=1 -> cycle+1: oup_valid=1, idx=1, data=0xA5, last=1; busy=0 one cycle after the pop.
REQ-022 Data sends a 4-beat message; Finish becomes valid after beat 1 -> Data beats 2-4 are emitted back to back before Finish; Finish appears on the cycle after Data's last pop.
REQ-023 All four sources valid with single-beat messages, ready=1 -> fixed priority: idx 0,0,0... while Finish stays valid; with RR_EN: idx 0,1,2,3,0.
REQ-024 oup_ready=0 for 5 cycles with oup_valid=1 -> outputs stable, inp_ready all 0; on ready=1 the next beat is emitted with no bubble.
REQ-025 rst_i asserted after beat 2 of a 4-beat Cfg message -> oup_valid=0 next cycle; after release, Grant wins in IDLE even if Cfg valid=1 (fixed priority).

Source files
------------

// File: rtl/xdma_to_remote_arbiter.sv
// xdma_to_remote_arbiter
// Message-granular arbiter that merges the to-remote message sources
// (0 Finish, 1 Grant, 2 Cfg, 3 Data) into one registered output stream.
// A source that wins keeps the grant until its last beat has been accepted.
//
// Build option: define XDMA_TO_REMOTE_ARB_RR_EN for round-robin selection in
// IDLE. Without it, selection is fixed priority with the lowest index winning,
// and no pointer register exists.
//
// oup_idx_o is two bits wide, so NumInp must not exceed 4.
module xdma_to_remote_arbiter #(
   parameter int unsigned NumInp    = 4,
   parameter int unsigned DataWidth = 512
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumInp-1:0][DataWidth-1:0] inp_data_i,
   input  logic [NumInp-1:0]                inp_last_i,
   input  logic [NumInp-1:0]                inp_valid_i,
   output logic [NumInp-1:0]                inp_ready_o,
   output logic [DataWidth-1:0]             oup_data_o,
   output logic [1:0]                       oup_idx_o,
   output logic                             oup_last_o,
   output logic                             oup_valid_o,
   input  logic                             oup_ready_i,
   output logic                             busy_o
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e               state_r;
   state_e               state_s;
   logic [1:0]           lock_idx_r;
   logic [1:0]           lock_idx_s;

   logic [1:0]           win_idx_s;
   logic                 win_valid_s;
   logic [1:0]           grant_idx_s;
   logic                 grant_valid_s;
   logic                 can_load_s;
   logic                 accept_s;
   logic                 accept_last_s;

   logic                 out_valid_r;
   logic                 out_valid_s;
   logic [DataWidth-1:0] out_data_r;
   logic [DataWidth-1:0] out_data_s;
   logic [1:0]           out_idx_r;
   logic [1:0]           out_idx_s;
   logic                 out_last_r;
   logic                 out_last_s;
   logic                 busy_r;
   logic                 busy_s;

`ifdef XDMA_TO_REMOTE_ARB_RR_EN
   logic [1:0]           rr_ptr_r;
   logic [1:0]           rr_ptr_s;
   logic [2:0]           cand_sum_s;
   logic [1:0]           cand_idx_s;

   // Round-robin search: first valid source at or after the pointer, wrapping.
   always_comb begin
      win_valid_s = 1'b0;
      win_idx_s   = rr_ptr_r;
      cand_sum_s  = 3'd0;
      cand_idx_s  = 2'd0;
      for (int k = 0; k < int'(NumInp); k++) begin
         cand_sum_s  = {1'b0, rr_ptr_r} + 3'(k);
         cand_idx_s  = (cand_sum_s >= 3'(NumInp)) ? 2'(cand_sum_s - 3'(NumInp))
                                                  : cand_sum_s[1:0];
         win_idx_s   = (!win_valid_s && inp_valid_i[cand_idx_s]) ? cand_idx_s : win_idx_s;
         win_valid_s = win_valid_s | inp_valid_i[cand_idx_s];
      end
   end

   // Pointer moves past the winner once its message has finished.
   always_comb begin
      rr_ptr_s = rr_ptr_r;
      if (accept_s && accept_last_s) begin
         rr_ptr_s = (grant_idx_s == 2'(NumInp - 1)) ? 2'd0 : grant_idx_s + 2'd1;
      end else begin
         rr_ptr_s = rr_ptr_r;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_r <= 2'd0;
      end else begin
         rr_ptr_r <= rr_ptr_s;
      end
   end
`else
   // Fixed priority: scan from the top so the lowest valid index wins.
   always_comb begin
      win_valid_s = 1'b0;
      win_idx_s   = 2'd0;
      for (int i = int'(NumInp) - 1; i >= 0; i--) begin
         win_idx_s   = inp_valid_i[i] ? 2'(i) : win_idx_s;
         win_valid_s = win_valid_s | inp_valid_i[i];
      end
   end
`endif

   // Grant selection: the locked source when locked, otherwise the arbiter winner.
   always_comb begin
      grant_idx_s   = win_idx_s;
      grant_valid_s = win_valid_s;
      case (state_r)
         ST_IDLE: begin
            grant_idx_s   = win_idx_s;
            grant_valid_s = win_valid_s;
         end
         ST_LOCKED: begin
            grant_idx_s   = lock_idx_r;
            grant_valid_s = inp_valid_i[lock_idx_r];
         end
         default: begin
            grant_idx_s   = 2'd0;
            grant_valid_s = 1'b0;
         end
      endcase
   end

   // Input acceptance: a beat is taken when the output register is free or draining.
   always_comb begin
      can_load_s    = !out_valid_r || oup_ready_i;
      accept_s      = grant_valid_s && can_load_s && !rst_i;
      accept_last_s = inp_last_i[grant_idx_s];
      inp_ready_o   = '0;
      for (int i = 0; i < int'(NumInp); i++) begin
         inp_ready_o[i] = accept_s && (grant_idx_s == 2'(i));
      end
   end

   // Next-state logic: lock on a non-last beat, release on the last beat.
   always_comb begin
      state_s    = state_r;
      lock_idx_s = lock_idx_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && !accept_last_s) begin
               state_s    = ST_LOCKED;
               lock_idx_s = grant_idx_s;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (accept_s && accept_last_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_LOCKED;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            lock_idx_s = 2'd0;
         end
      endcase
   end

   // Output register next value: load on accept, empty on pop, otherwise hold.
   always_comb begin
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      out_idx_s   = out_idx_r;
      out_last_s  = out_last_r;
      if (accept_s) begin
         out_valid_s = 1'b1;
         out_data_s  = inp_data_i[grant_idx_s];
         out_idx_s   = grant_idx_s;
         out_last_s  = accept_last_s;
      end else if (oup_ready_i) begin
         out_valid_s = 1'b0;
      end else begin
         out_valid_s = out_valid_r;
      end
      busy_s = (state_s == ST_LOCKED) || out_valid_s;
   end

   // State and lock index registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         lock_idx_r <= 2'd0;
      end else begin
         state_r    <= state_s;
         lock_idx_r <= lock_idx_s;
      end
   end

   // Output beat register and busy flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_idx_r   <= 2'd0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         out_idx_r   <= out_idx_s;
         out_last_r  <= out_last_s;
         busy_r      <= busy_s;
      end
   end

   assign oup_valid_o = out_valid_r;
   assign oup_data_o  = out_data_r;
   assign oup_idx_o   = out_idx_r;
   assign oup_last_o  = out_last_r;
   assign busy_o      = busy_r;

endmodule

// File: tb/tb_xdma_to_remote_arbiter.sv
// Testbench for xdma_to_remote_arbiter: per-source message queues drive the
// inputs, accepted beats go to a scoreboard, popped beats are compared against
// it, and the order of popped source indices is checked per scenario.
module tb_xdma_to_remote_arbiter;

   localparam int NUM = 4;
   localparam int DW  = 32;

   typedef struct packed {
      logic [1:0]    idx;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic                    clk;
   logic                    rst;
   logic [NUM-1:0][DW-1:0]  inp_data;
   logic [NUM-1:0]          inp_last;
   logic [NUM-1:0]          inp_valid;
   logic [NUM-1:0]          inp_ready;
   logic [DW-1:0]           oup_data;
   logic [1:0]              oup_idx;
   logic                    oup_last;
   logic                    oup_valid;
   logic                    oup_ready;
   logic                    busy;

   beat_t      src_q [NUM][$];
   beat_t      sb_q[$];
   logic [1:0] pop_idx_q[$];
   int         pop_cyc_q[$];
   logic [1:0] exp_idx_q[$];

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic [1:0]    prev_idx;
   logic          prev_last;

   xdma_to_remote_arbiter #(
      .NumInp    (NUM),
      .DataWidth (DW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .inp_data_i  (inp_data),
      .inp_last_i  (inp_last),
      .inp_valid_i (inp_valid),
      .inp_ready_o (inp_ready),
      .oup_data_o  (oup_data),
      .oup_idx_o   (oup_idx),
      .oup_last_o  (oup_last),
      .oup_valid_o (oup_valid),
      .oup_ready_i (oup_ready),
      .busy_o      (busy)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_msg(input int src, input int nbeats, input logic [DW-1:0] base);
      beat_t b;
      for (int k = 0; k < nbeats; k++) begin
         b.idx  = 2'(src);
         b.last = (k == nbeats - 1);
         b.data = base + DW'(k);
         src_q[src].push_back(b);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM; i++) begin
         if (src_q[i].size() > 0) begin
            inp_valid[i] = 1'b1;
            inp_data[i]  = src_q[i][0].data;
            inp_last[i]  = src_q[i][0].last;
         end else begin
            inp_valid[i] = 1'b0;
            inp_data[i]  = '0;
            inp_last[i]  = 1'b0;
         end
      end
   endtask

   // One clock: sample at negedge, apply handshake effects after posedge.
   task automatic step();
      logic [NUM-1:0] acc;
      logic           pop;
      logic [DW-1:0]  o_data;
      logic [1:0]     o_idx;
      logic           o_last;
      beat_t          e;
      @(negedge clk);
      acc    = inp_valid & inp_ready;
      pop    = oup_valid & oup_ready;
      o_data = oup_data;
      o_idx  = oup_idx;
      o_last = oup_last;
      check("ready_onehot0", 64'($onehot0(inp_ready)), 64'd1);
      if (rst) check("ready_in_reset", 64'(inp_ready), 64'd0);
      if (oup_valid && !oup_ready) check("ready_while_stalled", 64'(inp_ready), 64'd0);
      if (prev_stall) begin
         check("stall_valid", 64'(oup_valid), 64'd1);
         check("stall_data", 64'(oup_data), 64'(prev_data));
         check("stall_idx", 64'(oup_idx), 64'(prev_idx));
         check("stall_last", 64'(oup_last), 64'(prev_last));
      end
      prev_stall = oup_valid && !oup_ready && !rst;
      prev_data  = oup_data;
      prev_idx   = oup_idx;
      prev_last  = oup_last;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         sb_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (pop) begin
            if (sb_q.size() == 0) begin
               check("pop_without_accept", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("pop_data", 64'(o_data), 64'(e.data));
               check("pop_idx", 64'(o_idx), 64'(e.idx));
               check("pop_last", 64'(o_last), 64'(e.last));
            end
            pop_idx_q.push_back(o_idx);
            pop_cyc_q.push_back(cyc);
         end
         for (int i = 0; i < NUM; i++) begin
            if (acc[i]) begin
               sb_q.push_back(src_q[i].pop_front());
            end
         end
      end
      drive();
   endtask

   function automatic bit pending();
      bit p;
      p = (sb_q.size() > 0) || oup_valid;
      for (int i = 0; i < NUM; i++) p = p || (src_q[i].size() > 0);
      return p;
   endfunction

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         step();
         n++;
      end
      check(tag, 64'(pending()), 64'd0);
   endtask

   task automatic check_order(input string tag);
      check({tag, "_count"}, 64'(pop_idx_q.size()), 64'(exp_idx_q.size()));
      for (int i = 0; i < exp_idx_q.size() && i < pop_idx_q.size(); i++) begin
         check(tag, 64'(pop_idx_q[i]), 64'(exp_idx_q[i]));
      end
   endtask

   task automatic check_back_to_back(input string tag);
      for (int i = 1; i < pop_cyc_q.size(); i++) begin
         check(tag, 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'd1);
      end
   endtask

   task automatic clear_logs();
      pop_idx_q.delete();
      pop_cyc_q.delete();
      exp_idx_q.delete();
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      for (int k = 0; k < ncyc; k++) step();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      oup_ready = 1'b1;
      inp_valid = '0;
      inp_data  = '0;
      inp_last  = '0;

      // Reset with Grant already presenting a beat: no ready while in reset.
      push_msg(1, 1, 32'h0000_00A5);
      drive();
      do_reset(3);
      check("rst_valid", 64'(oup_valid), 64'd0);
      check("rst_data", 64'(oup_data), 64'd0);
      check("rst_idx", 64'(oup_idx), 64'd0);
      check("rst_last", 64'(oup_last), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // Single-beat Grant message: visible one cycle after acceptance.
      step();
      check("s21_valid", 64'(oup_valid), 64'd1);
      check("s21_idx", 64'(oup_idx), 64'd1);
      check("s21_data", 64'(oup_data), 64'h0000_00A5);
      check("s21_last", 64'(oup_last), 64'd1);
      check("s21_busy_full", 64'(busy), 64'd1);
      step();
      check("s21_valid_after_pop", 64'(oup_valid), 64'd0);
      check("s21_busy_after_pop", 64'(busy), 64'd0);
      exp_idx_q.push_back(2'd1);
      check_order("s21_order");
      clear_logs();

      // Data 4-beat message; Finish arrives after Data beat 1 and must wait.
      push_msg(3, 4, 32'h3000_0000);
      drive();
      for (int k = 0; k < 20 && src_q[3].size() > 3; k++) step();
      check("s22_beat1_taken", 64'(src_q[3].size()), 64'd3);
      check("s22_locked_busy", 64'(busy), 64'd1);
      push_msg(0, 1, 32'h0000_F00D);
      drive();
      drain("s22_drain", 50);
      exp_idx_q.push_back(2'd3);
      exp_idx_q.push_back(2'd3);
      exp_idx_q.push_back(2'd3);
      exp_idx_q.push_back(2'd3);
      exp_idx_q.push_back(2'd0);
      check_order("s22_order");
      check_back_to_back("s22_gap");
      clear_logs();

      // All four sources with single-beat messages; Finish has three.
      do_reset(2);
      push_msg(0, 1, 32'h0A00_0000);
      push_msg(0, 1, 32'h0A00_0010);
      push_msg(0, 1, 32'h0A00_0020);
      push_msg(1, 1, 32'h1B00_0000);
      push_msg(2, 1, 32'h2C00_0000);
      push_msg(3, 1, 32'h3D00_0000);
      drive();
      drain("s23_drain", 50);
`ifdef XDMA_TO_REMOTE_ARB_RR_EN
      exp_idx_q.push_back(2'd0);
      exp_idx_q.push_back(2'd1);
      exp_idx_q.push_back(2'd2);
      exp_idx_q.push_back(2'd3);
      exp_idx_q.push_back(2'd0);
      exp_idx_q.push_back(2'd0);
`else
      exp_idx_q.push_back(2'd0);
      exp_idx_q.push_back(2'd0);
      exp_idx_q.push_back(2'd0);
      exp_idx_q.push_back(2'd1);
      exp_idx_q.push_back(2'd2);
      exp_idx_q.push_back(2'd3);
`endif
      check_order("s23_order");
      check_back_to_back("s23_gap");
      clear_logs();

      // Downstream stall for 5 cycles with a 3-beat Grant message pending.
      oup_ready = 1'b0;
      push_msg(1, 3, 32'h1100_0000);
      drive();
      step();
      check("s24_first_loaded", 64'(oup_valid), 64'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         check("s24_stall_ready", 64'(inp_ready), 64'd0);
         check("s24_stall_data", 64'(oup_data), 64'h1100_0000);
      end
      oup_ready = 1'b1;
      drain("s24_drain", 50);
      exp_idx_q.push_back(2'd1);
      exp_idx_q.push_back(2'd1);
      exp_idx_q.push_back(2'd1);
      check_order("s24_order");
      check_back_to_back("s24_gap");
      clear_logs();

      // Reset after beat 2 of a 4-beat Cfg message.
      push_msg(2, 4, 32'h2200_0000);
      drive();
      for (int k = 0; k < 20 && src_q[2].size() > 2; k++) step();
      check("s25_two_taken", 64'(src_q[2].size()), 64'd2);
      exp_idx_q.push_back(2'd2);
      check_order("s25_pre_order");
      clear_logs();
      rst = 1'b1;
      step();
      check("s25_valid_dropped", 64'(oup_valid), 64'd0);
      check("s25_busy_dropped", 64'(busy), 64'd0);
      push_msg(1, 1, 32'h1200_00AA);
      rst = 1'b0;
      drive();
      drain("s25_drain", 50);
      exp_idx_q.push_back(2'd1);
      exp_idx_q.push_back(2'd2);
      exp_idx_q.push_back(2'd2);
      check_order("s25_post_order");
      clear_logs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
